// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit_serializer parallel-to-serial front end.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StParity = 2'b10,
    StGap    = 2'b11
  } state_e;

  localparam int unsigned GapCntW = 4;

  // Even parity: XOR of all bits; zero-extension of narrower words is harmless.
  function automatic logic parity_even(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// MSB-first word serializer with optional idle gap; idle line level is 0.
// Build option: define BIT_SERIALIZER_PARITY_EN to append an even-parity trailer bit.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_bit_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             word_done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [GapCntW-1:0] GapLoad = GapCntW'((GAP > 0) ? (GAP - 1) : 0);
  localparam state_e AfterWord = (GAP > 0) ? StGap : StIdle;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  state_e               state_q;
  logic [WIDTH-1:0]     shreg_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic [GapCntW-1:0]   gap_cnt_q;
  logic                 out_bit_q;
  logic                 out_valid_q;
  logic                 word_done_q;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic                 par_q;
`endif

  logic last_bit;
  logic handshake;

  assign last_bit    = (state_q == StShift) && (bit_cnt_q == '0);
  // Reload on the last-bit cycle only when nothing follows the word.
  assign in_ready_o  = (state_q == StIdle) || (last_bit && (GAP == 0) && !ParityEn);
  assign handshake   = in_valid_i && in_ready_o;

  assign out_bit_o   = out_bit_q;
  assign out_valid_o = out_valid_q;
  assign word_done_o = word_done_q;
  assign busy_o      = (state_q != StIdle);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      word_done_q <= 1'b0;
      if (handshake) begin
        // MSB goes straight to the output register; the rest waits in shreg_q.
        state_q     <= StShift;
        shreg_q     <= {in_data_i[WIDTH-2:0], 1'b0};
        bit_cnt_q   <= CntLast;
        out_bit_q   <= in_data_i[WIDTH-1];
        out_valid_q <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_q       <= parity_even(32'(in_data_i));
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
          end
          StShift: begin
            if (bit_cnt_q != '0) begin
              out_bit_q   <= shreg_q[WIDTH-1];
              out_valid_q <= 1'b1;
              shreg_q     <= {shreg_q[WIDTH-2:0], 1'b0};
              bit_cnt_q   <= bit_cnt_q - CntW'(1);
              word_done_q <= (bit_cnt_q == CntW'(1)) && !ParityEn;
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
              state_q     <= StParity;
              out_bit_q   <= par_q;
              out_valid_q <= 1'b1;
              word_done_q <= 1'b1;
`else
              state_q     <= AfterWord;
              gap_cnt_q   <= GapLoad;
              out_bit_q   <= 1'b0;
              out_valid_q <= 1'b0;
`endif
            end
          end
          StParity: begin
            state_q     <= AfterWord;
            gap_cnt_q   <= GapLoad;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
          end
          StGap: begin
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            if (gap_cnt_q == '0) begin
              state_q <= StIdle;
            end else begin
              gap_cnt_q <= gap_cnt_q - GapCntW'(1);
            end
          end
          default: begin
            state_q     <= StIdle;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized self-checking bench for bit_serializer; two instances (GAP=0 and GAP=3).
module tb_bit_serializer;

  localparam int W    = 8;
  localparam int GAP0 = 0;
  localparam int GAP1 = 3;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [1:0]   rdy, obit, oval, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles elapsed since the word was accepted (0 = idle).
  int           pos [2];
  logic [W-1:0] word [2];
  int           streak;
  int           streak_max;

  bit_serializer #(.WIDTH(W), .GAP(GAP0)) u_dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (rdy[0]),
    .in_data_i  (in_data),
    .out_bit_o  (obit[0]),
    .out_valid_o(oval[0]),
    .busy_o     (busy[0]),
    .word_done_o(done[0])
  );

  bit_serializer #(.WIDTH(W), .GAP(GAP1)) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (rdy[1]),
    .in_data_i  (in_data),
    .out_bit_o  (obit[1]),
    .out_valid_o(oval[1]),
    .busy_o     (busy[1]),
    .word_done_o(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  function automatic int len_of(input int i);
    return W + PAR + gap_of(i);
  endfunction

  function automatic logic exp_ready(input int i);
    return (pos[i] == 0) || (pos[i] == len_of(i) && PAR == 0 && gap_of(i) == 0);
  endfunction

  function automatic logic exp_valid(input int i);
    return (pos[i] >= 1) && (pos[i] <= W + PAR);
  endfunction

  function automatic logic exp_bit(input int i);
    logic [W-1:0] w;
    w = word[i];
    if (pos[i] >= 1 && pos[i] <= W) return w[W - pos[i]];
    if (PAR == 1 && pos[i] == W + 1) return ^w;
    return 1'b0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("dut%0d.in_ready", i), 32'(rdy[i]), 32'(exp_ready(i)));
      check_eq($sformatf("dut%0d.out_valid", i), 32'(oval[i]), 32'(exp_valid(i)));
      check_eq($sformatf("dut%0d.out_bit", i), 32'(obit[i]), 32'(exp_bit(i)));
      check_eq($sformatf("dut%0d.busy", i), 32'(busy[i]), 32'(pos[i] != 0));
      check_eq($sformatf("dut%0d.word_done", i), 32'(done[i]), 32'(pos[i] == W + PAR));
    end
  endtask

  task automatic tick();
    logic hs [2];
    for (int i = 0; i < 2; i++) hs[i] = in_valid && exp_ready(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin
        pos[i]  = 1;
        word[i] = in_data;
      end else if (pos[i] != 0) begin
        pos[i] = (pos[i] == len_of(i)) ? 0 : pos[i] + 1;
      end
    end
    streak = oval[0] ? streak + 1 : 0;
    if (streak > streak_max) streak_max = streak;
    check_outputs();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #1 rst = 1'b1;
    #1;
    pos[0] = 0;
    pos[1] = 0;
    check_outputs();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    pos[0]   = 0;
    pos[1]   = 0;
    word[0]  = '0;
    word[1]  = '0;
    streak   = 0;
    streak_max = 0;
    #12;
    check_outputs();
    rst = 1'b0;

    // Single word 0xD0 followed by idle.
    in_valid = 1'b1;
    in_data  = 8'hD0;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();

    // Back-to-back 0xDD, 0x0D with in_valid held high.
    streak_max = 0;
    in_valid   = 1'b1;
    in_data    = 8'hDD;
    tick();
    in_data = 8'h0D;
    repeat (8) tick();
    in_valid = 1'b0;
    repeat (14) tick();
    check_eq("b2b_valid_run", 32'(streak_max), 32'((PAR == 0) ? 2 * W : W + 1));

    // Continuous offer: second instance inserts its gap between words.
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (14) tick();

    // Reset after the third bit of 0xFF, then 0x80.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h3C;
    repeat (2) tick();
    mid_reset();
    in_valid = 1'b1;
    in_data  = 8'h80;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();

    // Randomized traffic with data churn while busy and rare resets.
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      tick();
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
